// File: rtl/risc_pkg.sv
// risc_pkg: shared core constants (instruction width, pc width, pc step, reset pc)
package risc_pkg;
  localparam int INST_W = 32;
  localparam int PC_W = 16;
  localparam int PC_STEP = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;
endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO; ports clk/rst, push/pop/flush, din, dout, full/empty/count; flush beats push and pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 48,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [DW-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push && !flush) mem_q[wr_q] <= din;
  always @(posedge clk) if (!rst && !flush) assert (!(push && full && !pop));
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetch with credit-limited requests, in-order response queue and redirect flush
// Ports: clk, rst; redirect_valid/redirect_pc; mem_req_valid/ready/addr; mem_rsp_valid/data;
//        inst_valid/inst_ready/inst/inst_pc towards the core.
// Optional FETCH_BYPASS_EN: a response reaching an empty queue goes straight to the core in the same cycle.
module inst_fetch_queue #(
  parameter int WIDTH = risc_pkg::INST_W,
  parameter int PC_W = risc_pkg::PC_W,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = risc_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [PC_W-1:0]  mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [PC_W-1:0]  inst_pc
);
  import risc_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic full, empty, push, pop, byp, req_fire;
  logic [PC_W+WIDTH-1:0] dout;
  // queued entries plus in-flight requests never exceed DEPTH, so every response has a slot
  assign mem_req_valid = !rst && !redirect_valid && (int'(count) + int'(out_q) < DEPTH);
  assign mem_req_addr = fetch_pc_q;
  assign req_fire = mem_req_valid && mem_req_ready;
`ifdef FETCH_BYPASS_EN
  assign byp = !rst && empty && drop_q == '0 && !redirect_valid && mem_rsp_valid && inst_ready;
`else
  assign byp = 1'b0;
`endif
  assign push = !rst && !redirect_valid && mem_rsp_valid && drop_q == '0 && !byp;
  assign pop = !rst && !redirect_valid && !empty && inst_ready;
  assign inst_valid = !rst && !redirect_valid && (!empty || byp);
  assign {inst_pc, inst} = byp ? {rsp_pc_q, mem_rsp_data} : empty ? '0 : dout;
  always_comb begin
    out_d = out_q + CW'(req_fire) - CW'(mem_rsp_valid);
    fetch_pc_d = redirect_valid ? redirect_pc : req_fire ? fetch_pc_q + PC_W'(PC_STEP) : fetch_pc_q;
    rsp_pc_d = redirect_valid ? redirect_pc :
               (mem_rsp_valid && drop_q == '0) ? rsp_pc_q + PC_W'(PC_STEP) : rsp_pc_q;
    // on redirect every request still in flight after this cycle belongs to the old stream
    drop_d = redirect_valid ? out_d : (mem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  always @(posedge clk) if (!rst) assert (!(mem_rsp_valid && out_q == '0));
  fetch_fifo #(.DEPTH(DEPTH), .DW(PC_W + WIDTH), .CW(CW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect_valid),
    .din({rsp_pc_q, mem_rsp_data}), .full(full), .empty(empty), .count(count), .dout(dout)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue with a fixed-latency memory model
module tb_inst_fetch_queue;
  localparam int W = 32;
  localparam int P = 16;
`ifdef FETCH_BYPASS_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 2;
`endif
  logic clk = 0, rst = 1, redirect_valid = 0, mem_req_ready = 1, mem_rsp_valid = 0, inst_ready = 1;
  logic [P-1:0] redirect_pc = '0;
  logic [W-1:0] mem_rsp_data = '0;
  logic mem_req_valid, inst_valid;
  logic [P-1:0] mem_req_addr, inst_pc;
  logic [W-1:0] inst;
  int checks = 0, failures = 0, lat = 1, fires = 0;
  logic [2:0] pv = '0;
  logic [P-1:0] pa [3] = '{default: '0};
  logic ovr_en = 0;
  logic [W-1:0] ovr = '0;
  always #5 clk = ~clk;
  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );
  function automatic logic [W-1:0] mk(input logic [P-1:0] a);
    return {16'hC0DE, a};
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: sample request handshake before the edge, drive the response for the new cycle after it
  task automatic tick();
    logic f;
    logic [P-1:0] a;
    @(negedge clk);
    f = mem_req_valid && mem_req_ready;
    a = mem_req_addr;
    if (f) fires++;
    @(posedge clk);
    #1;
    if (rst) pv = '0;
    else begin
      pv = {pv[1:0], f};
      pa[2] = pa[1];
      pa[1] = pa[0];
      pa[0] = a;
    end
    mem_rsp_valid = pv[lat-1];
    mem_rsp_data = ovr_en ? ovr : mk(pa[lat-1]);
    ovr_en = 0;
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    tick();
    tick();
    rst = 0;
    #1;
  endtask
  initial begin
    // 1: reset values, then steady sequential stream
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    tick();
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    tick();
    rst = 0;
    #1;
    chk("t1_addr0", mem_req_addr, 0);
    chk("t1_req_valid0", mem_req_valid, 1);
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk("t1_addr", mem_req_addr, 32'(4 * n));
      chk("t1_req_valid", mem_req_valid, 1);
      chk("t1_inst_valid", inst_valid, n >= OFF);
      if (n >= OFF) begin
        chk("t1_pc", inst_pc, 32'(4 * (n - OFF)));
        chk("t1_inst", inst, mk(16'(4 * (n - OFF))));
      end
    end
    // 2: core stalled, credit limit, then drain and resume at 0x10
    inst_ready = 0;
    do_reset();
    fires = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("t2_fires", fires, 4);
    chk("t2_req_stall", mem_req_valid, 0);
    chk("t2_head_valid", inst_valid, 1);
    chk("t2_head_pc", inst_pc, 0);
    inst_ready = 1;
    #1;
    chk("t2_full_req", mem_req_valid, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk("t2_pop_valid", inst_valid, 1);
      chk("t2_pop_pc", inst_pc, 32'(4 * k));
      chk("t2_pop_inst", inst, mk(16'(4 * k)));
      if (k == 1) begin
        chk("t2_resume_valid", mem_req_valid, 1);
        chk("t2_resume_addr", mem_req_addr, 32'h10);
      end
    end
    // 3: redirect with two requests in flight (latency 3)
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1;
    redirect_pc = 16'h0100;
    #1;
    chk("t3_redir_req", mem_req_valid, 0);
    chk("t3_redir_inst", inst_valid, 0);
    tick();
    redirect_valid = 0;
    #1;
    chk("t3_addr", mem_req_addr, 32'h100);
    chk("t3_req_valid", mem_req_valid, 1);
    for (int c = 3; c <= 8; c++) begin
      if (c > 3) tick();
      chk("t3_inst_valid", inst_valid, c >= 5 + OFF);
      if (c >= 5 + OFF) chk("t3_pc", inst_pc, 32'(16'h100 + 4 * (c - 5 - OFF)));
    end
    // 4: address wrap at the top of the pc space
    lat = 1;
    do_reset();
    redirect_valid = 1;
    redirect_pc = 16'hFFF8;
    #1;
    chk("t4_redir_req", mem_req_valid, 0);
    tick();
    redirect_valid = 0;
    #1;
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) tick();
      chk("t4_addr", mem_req_addr, 32'(16'(16'hFFF8 + 4 * (n - 1))));
      chk("t4_inst_valid", inst_valid, n - 1 >= OFF);
      if (n - 1 >= OFF) chk("t4_pc", inst_pc, 32'(16'(16'hFFF8 + 4 * (n - 1 - OFF))));
    end
    // 5: back-to-back redirects, last one wins; then reset mid-stream
    do_reset();
    tick();
    tick();
    tick();
    redirect_valid = 1;
    redirect_pc = 16'h40;
    #1;
    chk("t5_redir1_inst", inst_valid, 0);
    tick();
    redirect_pc = 16'h80;
    #1;
    chk("t5_redir2_req", mem_req_valid, 0);
    chk("t5_redir2_inst", inst_valid, 0);
    tick();
    redirect_valid = 0;
    #1;
    chk("t5_addr", mem_req_addr, 32'h80);
    chk("t5_req_valid", mem_req_valid, 1);
    for (int c = 5; c <= 8; c++) begin
      if (c > 5) tick();
      chk("t5_inst_valid", inst_valid, c >= 5 + OFF);
      if (c >= 5 + OFF) chk("t5_pc", inst_pc, 32'(16'h80 + 4 * (c - 5 - OFF)));
    end
    rst = 1;
    #1;
    chk("t5_rst_req", mem_req_valid, 0);
    chk("t5_rst_inst_valid", inst_valid, 0);
    tick();
    chk("t5_rst_inst", inst, 0);
    chk("t5_rst_pc", inst_pc, 0);
    rst = 0;
    #1;
    chk("t5_restart_valid", mem_req_valid, 1);
    chk("t5_restart_addr", mem_req_addr, 0);
    tick();
    chk("t5_restart_addr1", mem_req_addr, 4);
    // 6: response into an empty queue
    lat = 1;
    do_reset();
    ovr = 32'hDEADBEEF;
    ovr_en = 1;
    tick();
`ifdef FETCH_BYPASS_EN
    chk("t6_byp_valid", inst_valid, 1);
    chk("t6_byp_inst", inst, 32'hDEADBEEF);
    chk("t6_byp_pc", inst_pc, 0);
    tick();
    chk("t6_next_pc", inst_pc, 4);
    chk("t6_next_inst", inst, mk(16'h4));
`else
    chk("t6_same_cycle_valid", inst_valid, 0);
    tick();
    chk("t6_valid", inst_valid, 1);
    chk("t6_inst", inst, 32'hDEADBEEF);
    chk("t6_pc", inst_pc, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
